ultrasound_scheduler: RTL
=========================

Name: ultrasound_scheduler

Overview:
- Sequences the ring of ultrasound transducers on behalf of main_fsm.
- Fires each sensor in turn, times its echo and converts the echo width to a range.
- Keeps the nearest valid return and reports it as rover_location: theta index in [11:8], r in [7:0].
- Handshake with main_fsm is run / done, replacing the single-sensor ultrasound block.

Parameters:
- NUM_SENSORS, 12: transducer count, 1..16; the index becomes theta.
- TRIGGER_CYCLES, 270: trigger pulse width (10 us at 27 MHz).
- CYCLES_PER_INCH, 3996: echo cycles per r unit.
- TIMEOUT_CYCLES, 1026000: max cycles from trigger end to echo fall.
- SETTLE_CYCLES, 1350000: dead time between pings (crosstalk).
- MIN_VALID_R, 2: ranges below this are discarded.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low; 0 = reset
- run  in  1  start request, sampled in IDLE only
- echo  in  NUM_SENSORS  raw asynchronous echo lines
- trigger  out  NUM_SENSORS  one-hot trigger, at most one bit high
- busy  out  1  high from start until done
- done  out  1  one-cycle pulse when the scan result is valid
- found  out  1  at least one valid return in the last scan
- rover_location  out  12  {best_idx[3:0], best_r[7:0]}
- current_sensor  out  4  sensor being serviced (debug)

Behaviour:
- Reset: asynchronous, active-low, one clock domain. While reset=0, all outputs go to 0, the state goes to IDLE and the echo synchronisers clear.
- Echo input: each echo bit passes through a 2-FF synchroniser. All echo decisions use the synchronised value.
- States: IDLE, TRIGGER, WAIT_RISE, MEASURE, SETTLE, REPORT.
- IDLE:
  - On run=1: idx=0, best_r=8'hFF, best_idx=0, hit=0, busy=1, counters=0, go to TRIGGER.
  - run=1 while busy=1 is ignored; no queuing.
- TRIGGER: trigger[idx]=1 for exactly TRIGGER_CYCLES cycles, then trigger=0, timeout counter=0, go to WAIT_RISE.
- WAIT_RISE:
  - timeout counter increments every cycle.
  - Synchronised echo[idx]=1: go to MEASURE with unit counter=0 and r_count=0.
  - Counter reaches TIMEOUT_CYCLES-1: go to SETTLE; no reading taken.
- MEASURE:
  - Timeout counter keeps running. Unit counter wraps every CYCLES_PER_INCH cycles, and each wrap increments r_count.
  - r_count saturates at 8'hFF.
  - On echo fall, accept r_count only if r_count >= MIN_VALID_R and r_count < best_r (strict). Accept means best_r=r_count, best_idx=idx, hit=1. Then go to SETTLE.
  - Timeout expiry during MEASURE discards the reading and goes to SETTLE.
- SETTLE:
  - Wait SETTLE_CYCLES.
  - If idx==NUM_SENSORS-1 go to REPORT; otherwise idx=idx+1 and go to TRIGGER.
- REPORT (one cycle):
  - If hit: rover_location={best_idx,best_r}, found=1.
  - If no hit: rover_location=12'h000, found=0.
  - done=1 for this cycle only; busy=0 on the next cycle; return to IDLE.
- Output stability: rover_location and found are held until the next REPORT or reset. main_fsm may sample them on or after done.
- Ties: the equal range on a higher index loses, so the lowest index wins.
- Echoes on non-selected sensors are ignored.
- Echo already high on entry to WAIT_RISE (stale ringing): treated as a rise. Bench keeps echo low during trigger.
- current_sensor = idx while busy, 0 otherwise.
- Widths: the timeout counter is sized by clog2(TIMEOUT_CYCLES). idx and best_idx are 4 bits.
- Latency: the synchroniser adds 2 cycles to both edges, so r = floor(echo_high_cycles / CYCLES_PER_INCH), with ±1 cycle tolerance at boundaries.

Optional Feature:
- Macro: ULTRASOUND_RETRY_EN.
- Defined: a sensor that times out in WAIT_RISE or MEASURE is re-fired once. The path is SETTLE, then TRIGGER with the same idx, tracked by a retry flag cleared on idx advance. A second timeout moves on.
- Not defined: no retry; a timed-out sensor is skipped.
- Scan-time bound: worst case is 2x when the macro is defined.

Test Plan (NUM_SENSORS=4, TRIGGER_CYCLES=4, CYCLES_PER_INCH=10, TIMEOUT_CYCLES=2000, SETTLE_CYCLES=8, MIN_VALID_R=2; retry off unless stated):
1. reset=0 mid-clock with run=1 -> trigger=0, busy=0, done=0, found=0, rover_location=12'h000, with no clock edge needed.
2. run pulse; echo[2] high 155 cycles, 20 cycles after its trigger falls; others silent -> trigger pulses 4 cycles on bits 0,1,2,3 in order; one done pulse; found=1; rover_location=12'h20F.
3. echo[1] and echo[3] each high 50 cycles; echo[0] high 120 cycles -> rover_location=12'h105 (lowest index wins the tie at r=5).
4. No echoes -> each sensor waits 2000 cycles; done after roughly 4*(4+2000+8) cycles; found=0; rover_location=12'h000.
5. echo[0] high 15 cycles (r=1 < MIN_VALID_R), others silent -> found=0. Then a second run with echo[3] high 300 cycles -> rover_location=12'h31E. run asserted while busy is ignored (single done).
6. reset=0 during MEASURE of sensor 1, then released and run -> full fresh scan from sensor 0. With ULTRASOUND_RETRY_EN and silent sensors: sensor 0 triggered twice before sensor 1.

Source files
------------

// File: rtl/ultrasound_scheduler.sv
// ultrasound_scheduler: fires a ring of ultrasound transducers in turn and reports the nearest valid return.
// Define ULTRASOUND_RETRY_EN to re-fire a timed-out sensor once before moving on.
module ultrasound_scheduler #(
    parameter int NUM_SENSORS     = 12,
    parameter int TRIGGER_CYCLES  = 270,
    parameter int CYCLES_PER_INCH = 3996,
    parameter int TIMEOUT_CYCLES  = 1026000,
    parameter int SETTLE_CYCLES   = 1350000,
    parameter int MIN_VALID_R     = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trigger,
    output logic                   busy,
    output logic                   done,
    output logic                   found,
    output logic [11:0]            rover_location,
    output logic [3:0]             current_sensor
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int PW = $clog2((SETTLE_CYCLES > TRIGGER_CYCLES ? SETTLE_CYCLES : TRIGGER_CYCLES) + 1);
    localparam int UW = $clog2(CYCLES_PER_INCH + 1);

    typedef enum logic [2:0] {IDLE, TRIGGER, WAIT_RISE, MEASURE, SETTLE, REPORT} state_t;
    state_t state, state_n;

    logic [NUM_SENSORS-1:0] s1, s2, sel;
    logic [PW-1:0]          pcnt;
    logic [TW-1:0]          tcnt;
    logic [UW-1:0]          ucnt, ucnt_n;
    logic [7:0]             r_count, r_inc, best_r;
    logic [3:0]             idx, best_idx;
    logic                   hit, e, u_wrap, t_end, trig_end, set_end, last, accept, again;

    assign sel            = NUM_SENSORS'(1) << idx;
    assign e              = |(s2 & sel);
    assign trigger        = (state == TRIGGER) ? sel : '0;
    assign busy           = state != IDLE;
    assign done           = state == REPORT;
    assign current_sensor = busy ? idx : 4'd0;
    assign trig_end       = pcnt == PW'(TRIGGER_CYCLES - 1);
    assign set_end        = pcnt == PW'(SETTLE_CYCLES - 1);
    assign t_end          = tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign last           = idx == 4'(NUM_SENSORS - 1);
    assign u_wrap         = ucnt == UW'(CYCLES_PER_INCH - 1);
    assign ucnt_n         = u_wrap ? '0 : ucnt + 1'b1;
    // The falling-edge cycle is counted too, so it makes up for the rise cycle spent in WAIT_RISE.
    assign r_inc          = (u_wrap && r_count != 8'hFF) ? r_count + 8'd1 : r_count;
    assign accept         = r_inc >= 8'(MIN_VALID_R) && r_inc < best_r;

`ifdef ULTRASOUND_RETRY_EN
    logic redo, retry, timeout;
    assign timeout = t_end && ((state == WAIT_RISE && !e) || (state == MEASURE && e));
    assign again   = redo;
`else
    assign again   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = run ? TRIGGER : IDLE;
            TRIGGER:   state_n = trig_end ? WAIT_RISE : TRIGGER;
            WAIT_RISE: state_n = e ? MEASURE : (t_end ? SETTLE : WAIT_RISE);
            MEASURE:   state_n = (!e || t_end) ? SETTLE : MEASURE;
            SETTLE:    state_n = !set_end ? SETTLE : ((again || !last) ? TRIGGER : REPORT);
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1             <= '0;
            s2             <= '0;
            pcnt           <= '0;
            tcnt           <= '0;
            ucnt           <= '0;
            r_count        <= '0;
            idx            <= '0;
            best_idx       <= '0;
            best_r         <= '0;
            hit            <= 1'b0;
            found          <= 1'b0;
            rover_location <= '0;
`ifdef ULTRASOUND_RETRY_EN
            redo           <= 1'b0;
            retry          <= 1'b0;
`endif
        end else begin
            s1      <= echo;
            s2      <= s1;
            pcnt    <= (state_n != state) ? '0 : pcnt + 1'b1;
            tcnt    <= (state == WAIT_RISE || state == MEASURE) ? tcnt + 1'b1 : '0;
            ucnt    <= (state == MEASURE) ? ucnt_n : '0;
            r_count <= (state == MEASURE) ? r_inc : '0;
            if (state == IDLE && run) begin
                idx      <= '0;
                best_r   <= 8'hFF;
                best_idx <= '0;
                hit      <= 1'b0;
            end
            if (state == MEASURE && !e && accept) begin
                best_r   <= r_inc;
                best_idx <= idx;
                hit      <= 1'b1;
            end
            if (state == SETTLE && set_end && !again && !last) idx <= idx + 4'd1;
            if (state == SETTLE && state_n == REPORT) begin
                found          <= hit;
                rover_location <= hit ? {best_idx, best_r} : 12'h000;
            end
`ifdef ULTRASOUND_RETRY_EN
            if (state == IDLE && run) begin
                redo  <= 1'b0;
                retry <= 1'b0;
            end
            if (timeout) redo <= !retry;
            if (state == SETTLE && set_end) begin
                retry <= redo;
                redo  <= 1'b0;
            end
`endif
        end
    end
endmodule
